// File: rtl/neuron_pkg.sv
// Shared constants and FSM encoding for the time-multiplexed LIF neuron scheduler.
package neuron_pkg;

  localparam int N_NEURONS_DEF = 8;
  localparam int N_INPUTS_DEF  = 8;
  localparam int WIDTH_DEF     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACC,
    S_FIRE,
    S_WB,
    S_DONE
  } state_t;

endpackage

// File: rtl/neuron_step_scheduler_sat_add.sv
// Signed two's-complement adder that clamps to the representable range instead of wrapping.
module sat_add #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum
);

  logic signed [WIDTH:0] full;

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    full = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    sum  = full[WIDTH-1:0];
    // Sign bits disagree only when the true sum left the WIDTH-bit range.
    if (full[WIDTH] != full[WIDTH-1]) begin
      sum = full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/neuron_step_scheduler.sv
// Walks every neuron through leak, weighted-input accumulation and fire/write-back once per
// timestep, driving an external membrane accumulator and a 1-cycle-latency weight memory.
module neuron_step_scheduler
  import neuron_pkg::*;
#(
  parameter int N_NEURONS = N_NEURONS_DEF,
  parameter int N_INPUTS  = N_INPUTS_DEF,
  parameter int WIDTH     = WIDTH_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      done,
  input  logic [N_INPUTS-1:0]                       spike_in,
  input  logic [2:0]                                beta_shift,
  input  logic signed [WIDTH-1:0]                   theta,
  output logic [$clog2(N_NEURONS*N_INPUTS)-1:0]     w_addr,
  input  logic signed [WIDTH-1:0]                   w_data,
  output logic signed [WIDTH-1:0]                   acc_beta_u,
  output logic signed [WIDTH-1:0]                   acc_sum_wx,
  output logic signed [WIDTH-1:0]                   acc_minus_teta,
  output logic                                      acc_was_spike,
  input  logic signed [WIDTH-1:0]                   acc_u_out,
  output logic [N_NEURONS-1:0]                      spike_out
);

  localparam int AW = $clog2(N_NEURONS * N_INPUTS);
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int CW = $clog2(N_INPUTS + 1);
  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1);

  state_t                  state;
  logic [NW-1:0]           n;
  logic [CW-1:0]           cnt;
  logic signed [WIDTH-1:0] u [N_NEURONS];
  logic [N_NEURONS-1:0]    spk;
  logic [N_NEURONS-1:0]    spk_next;
  logic [N_NEURONS-1:0]    spk_next_w;
  logic [N_INPUTS-1:0]     spk_lat;
  logic [N_INPUTS-1:0]     spk_sh;
  logic [2:0]              shift_lat;
  logic signed [WIDTH-1:0] theta_lat;
  logic signed [WIDTH-1:0] beta_u;
  logic signed [WIDTH-1:0] sum_wx;
  logic signed [WIDTH-1:0] sat_sum;
  logic signed [WIDTH-1:0] sum_add;
  logic signed [WIDTH-1:0] neg_theta;
  logic signed [WIDTH-1:0] u_cur;
  logic signed [WIDTH-1:0] beta_calc;
  logic                    fired;
  logic                    last_neuron;

  sat_add #(.WIDTH(WIDTH)) u_acc_add (.a(sum_wx), .b(w_data), .sum(sat_sum));

  // -theta as ~theta + 1, so theta = min folds to max instead of wrapping.
  sat_add #(.WIDTH(WIDTH)) u_neg_theta (.a(~theta_lat), .b(ONE), .sum(neg_theta));

  assign u_cur       = u[n];
  assign fired       = (acc_u_out >= theta_lat);
  assign last_neuron = (n == NW'(N_NEURONS - 1));
  assign spike_out   = spk;

  always_comb begin
    beta_calc = (shift_lat == 3'd0) ? u_cur : u_cur - (u_cur >>> shift_lat);
    // Weight data lags its address by one cycle, so ACC cycle k consumes input k-1.
    sum_add   = ((cnt != '0) && spk_sh[0]) ? sat_sum : sum_wx;
    spk_next_w    = spk_next;
    spk_next_w[n] = fired;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      n              <= '0;
      cnt            <= '0;
      w_addr         <= '0;
      spk_lat        <= '0;
      spk_sh         <= '0;
      shift_lat      <= '0;
      theta_lat      <= '0;
      beta_u         <= '0;
      sum_wx         <= '0;
      spk            <= '0;
      spk_next       <= '0;
      acc_beta_u     <= '0;
      acc_sum_wx     <= '0;
      acc_minus_teta <= '0;
      acc_was_spike  <= 1'b0;
      // NOTE: u is a small flop array rather than a RAM macro, so clearing it in reset is legal.
      for (int i = 0; i < N_NEURONS; i++) u[i] <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            spk_lat   <= spike_in;
            shift_lat <= beta_shift;
            theta_lat <= theta;
            n         <= '0;
            w_addr    <= '0;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          beta_u <= beta_calc;
          sum_wx <= '0;
          cnt    <= '0;
          spk_sh <= spk_lat;
          state  <= S_ACC;
        end
        S_ACC: begin
          if (cnt != '0) begin
            sum_wx <= sum_add;
            spk_sh <= spk_sh >> 1;
          end
          if (cnt < CW'(N_INPUTS - 1)) w_addr <= w_addr + AW'(1);
          if (cnt == CW'(N_INPUTS)) begin
            acc_beta_u     <= beta_u;
            acc_sum_wx     <= sum_add;
            acc_minus_teta <= neg_theta;
            acc_was_spike  <= spk[n];
            state          <= S_FIRE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_FIRE: begin
          acc_beta_u     <= '0;
          acc_sum_wx     <= '0;
          acc_minus_teta <= '0;
          acc_was_spike  <= 1'b0;
          state          <= S_WB;
        end
        S_WB: begin
          u[n]     <= acc_u_out;
          spk_next <= spk_next_w;
          if (last_neuron) begin
            // Spike flags publish together with done; a reset before here leaves them untouched.
            spk    <= spk_next_w;
            w_addr <= '0;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            n      <= n + NW'(1);
            w_addr <= w_addr + AW'(1);
            state  <= S_LOAD;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a negedge monitor checks them.
module tb_neuron_step_scheduler;

  localparam int N  = 8;
  localparam int I  = 8;
  localparam int W  = 8;
  localparam int TS = N * (I + 4);

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                busy;
  logic                done;
  logic [I-1:0]        spike_in;
  logic [2:0]          beta_shift;
  logic signed [W-1:0] theta;
  logic [5:0]          w_addr;
  logic signed [W-1:0] w_data;
  logic signed [W-1:0] acc_beta_u;
  logic signed [W-1:0] acc_sum_wx;
  logic signed [W-1:0] acc_minus_teta;
  logic                acc_was_spike;
  logic signed [W-1:0] acc_u_out;
  logic [N-1:0]        spike_out;

  always #5 clk = ~clk;

  neuron_step_scheduler #(.N_NEURONS(N), .N_INPUTS(I), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .spike_in(spike_in), .beta_shift(beta_shift), .theta(theta),
    .w_addr(w_addr), .w_data(w_data),
    .acc_beta_u(acc_beta_u), .acc_sum_wx(acc_sum_wx), .acc_minus_teta(acc_minus_teta),
    .acc_was_spike(acc_was_spike), .acc_u_out(acc_u_out), .spike_out(spike_out)
  );

  function automatic logic signed [7:0] sat8(input int v);
    if (v > 127) return 8'sd127;
    if (v < -128) return -8'sd128;
    return 8'(v);
  endfunction

  // External weight memory and accumulator models (reset-by-subtraction LIF update).
  logic signed [W-1:0] wmem [N*I];
  always @(posedge clk) w_data <= wmem[w_addr];
  always @(posedge clk)
    if (rst) acc_u_out <= '0;
    else acc_u_out <= sat8(int'(acc_beta_u) + int'(acc_sum_wx) +
                           (acc_was_spike ? int'(acc_minus_teta) : 0));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {int bu; int sum; int mt; int ws;} fire_t;
  fire_t        fire_q[$];
  logic [N-1:0] done_q[$];
  int           u_ref[N];
  logic [N-1:0] spk_ref;
  int           obs_beta[N];
  int           obs_sum[N];
  int           obs_mt;

  task automatic model_step(input logic [I-1:0] sp, input logic [2:0] bs,
                            input logic signed [W-1:0] th);
    int mt, bu, s, uo;
    logic [N-1:0] nxt;
    mt = sat8(-int'(th));
    nxt = '0;
    for (int nn = 0; nn < N; nn++) begin
      bu = (bs == 3'd0) ? u_ref[nn] : u_ref[nn] - (u_ref[nn] >>> bs);
      s = 0;
      for (int i = 0; i < I; i++) if (sp[i]) s = sat8(s + int'(wmem[nn*I+i]));
      fire_q.push_back('{bu, s, mt, int'(spk_ref[nn])});
      uo = sat8(bu + s + (spk_ref[nn] ? mt : 0));
      u_ref[nn] = uo;
      nxt[nn] = (uo >= int'(th));
    end
    spk_ref = nxt;
    done_q.push_back(nxt);
  endtask

  // Monitor: FIRE cycles are recognised by position within the busy window.
  initial begin : monitor
    int k, zero_bad, nidx;
    fire_t f;
    k = 0;
    zero_bad = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        k = 0;
        zero_bad = 0;
      end else if (busy !== 1'b1) begin
        k = 0;
        zero_bad = 0;
        if (done === 1'b1) check("done_while_idle", 1, 0);
      end else begin
        if (k % (I + 4) == I + 2) begin
          nidx = k / (I + 4);
          if (fire_q.size() == 0) check("fire_unexpected", 1, 0);
          else begin
            f = fire_q.pop_front();
            check("acc_beta_u", acc_beta_u, f.bu);
            check("acc_sum_wx", acc_sum_wx, f.sum);
            check("acc_minus_teta", acc_minus_teta, f.mt);
            check("acc_was_spike", acc_was_spike, f.ws);
            obs_beta[nidx] = acc_beta_u;
            obs_sum[nidx]  = acc_sum_wx;
            obs_mt         = acc_minus_teta;
          end
        end else if (acc_beta_u != 0 || acc_sum_wx != 0 || acc_minus_teta != 0 || acc_was_spike != 0)
          zero_bad++;
        if (done === 1'b1) begin
          check("done_cycle", k, TS);
          if (done_q.size() == 0) check("done_unexpected", 1, 0);
          else check("spike_out", spike_out, done_q.pop_front());
          check("operands_zero_outside_fire", zero_bad, 0);
        end
        k++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    fire_q.delete();
    done_q.delete();
    for (int i = 0; i < N; i++) u_ref[i] = 0;
    spk_ref = '0;
  endtask

  // mode 1: extra start pulses mid-timestep and on the done cycle, all to be ignored.
  task automatic run_step(input logic [I-1:0] sp, input logic [2:0] bs,
                          input logic signed [W-1:0] th, input int mode);
    bit got;
    model_step(sp, bs, th);
    @(posedge clk); #1;
    spike_in = sp; beta_shift = bs; theta = th; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    spike_in = I'($urandom); beta_shift = 3'($urandom); theta = W'($urandom);
    got = 1'b0;
    for (int c = 1; c <= 200 && !got; c++) begin
      @(posedge clk); #1;
      start = (mode == 1) && (c == 5 || c == 40);
      if (done === 1'b1) begin
        got = 1'b1;
        if (mode == 1) start = 1'b1;
      end
    end
    check("done_seen", got, 1);
    if (mode == 1) begin
      @(posedge clk); #1 start = 1'b0;
      check("start_on_done_ignored", busy, 0);
      repeat (3) begin
        @(posedge clk); #1;
        check("stays_idle", busy, 0);
      end
    end
  endtask

  task automatic reset_mid(input logic [I-1:0] sp);
    model_step(sp, 3'd0, 8'sd100);
    @(posedge clk); #1;
    spike_in = sp; beta_shift = 3'd0; theta = 8'sd100; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3 * (I + 4) + 2) @(posedge clk);
    #1;
    check("mid_acc_busy", busy, 1);
    check("spike_out_held_mid_step", spike_out, 8'hFF);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_spike_out", spike_out, 0);
    fire_q.delete();
    done_q.delete();
    for (int i = 0; i < N; i++) u_ref[i] = 0;
    spike_ref_clear();
  endtask

  task automatic spike_ref_clear();
    spk_ref = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; spike_in = '0; beta_shift = '0; theta = '0;
    for (int i = 0; i < N*I; i++) wmem[i] = '0;
    do_reset();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_spike_out", spike_out, 0);
    check("reset_w_addr", w_addr, 0);
    check("reset_acc_beta_u", acc_beta_u, 0);
    check("reset_acc_sum_wx", acc_sum_wx, 0);
    check("reset_acc_minus_teta", acc_minus_teta, 0);
    check("reset_acc_was_spike", acc_was_spike, 0);

    // All weights +20, all inputs active: sum clamps at 127, every neuron fires.
    for (int i = 0; i < N*I; i++) wmem[i] = 8'sd20;
    run_step(8'hFF, 3'd0, 8'sd100, 0);
    check("pos_sat_spike_out", spike_out, 8'hFF);
    for (int i = 0; i < N; i++) check("pos_sat_sum", obs_sum[i], 127);

    // Build u = 50 everywhere, then leak by half with no input.
    do_reset();
    for (int i = 0; i < N*I; i++) wmem[i] = (i % I == 0) ? 8'sd50 : 8'sd0;
    run_step(8'h01, 3'd0, 8'sd100, 0);
    check("u50_spike_out", spike_out, 8'h00);
    run_step(8'h00, 3'd1, 8'sd100, 0);
    check("leak_spike_out", spike_out, 8'h00);
    for (int i = 0; i < N; i++) begin
      check("leak_beta_u", obs_beta[i], 25);
      check("leak_sum_wx", obs_sum[i], 0);
    end

    // All weights -128: sum clamps at -128 without wrapping.
    for (int i = 0; i < N*I; i++) wmem[i] = -8'sd128;
    run_step(8'hFF, 3'd0, 8'sd100, 0);
    check("neg_sat_spike_out", spike_out, 8'h00);
    for (int i = 0; i < N; i++) check("neg_sat_sum", obs_sum[i], -128);

    // theta = -128: its negation clamps at +127; u = -103 still clears the threshold.
    run_step(8'h00, 3'd0, -8'sd128, 0);
    check("theta_min_negation", obs_mt, 127);
    check("theta_min_spike_out", spike_out, 8'hFF);

    reset_mid(8'hFF);
    run_step(8'h00, 3'd0, 8'sd0, 0);
    check("after_reset_spike_out", spike_out, 8'hFF);

    for (int i = 0; i < N*I; i++) wmem[i] = W'((i % 16) - 8);
    run_step(8'hA5, 3'd2, 8'sd10, 1);

    for (int t = 0; t < 100; t++) begin
      for (int i = 0; i < N*I; i++) wmem[i] = W'($urandom_range(0, 255));
      run_step(I'($urandom), 3'($urandom_range(0, 7)), W'($urandom_range(0, 255)), 0);
    end

    repeat (2) @(posedge clk);
    #1;
    check("fire_queue_drained", fire_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_step_scheduler.md
NEURON_STEP_SCHEDULER -- requirements
Module: neuron_step_scheduler

Interface
REQ-001 SHALL have parameter N_NEURONS, default 8: neurons time-multiplexed onto one membrane-potential accumulator.
REQ-002 SHALL have parameter N_INPUTS, default 8: synaptic inputs per neuron.
REQ-003 SHALL have parameter WIDTH, default 8: signed potential/weight width, equal to accumulator n_stage+2.
REQ-004 SHALL have ports: clk  in  1  single clock; rising edge only.
REQ-005 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: start  in  1  pulse; begin one timestep over all neurons.
REQ-007 SHALL have ports: busy  out  1  high while a timestep is in progress.
REQ-008 SHALL have ports: done  out  1  one-cycle pulse at timestep end.
REQ-009 SHALL have ports: spike_in  in  N_INPUTS  input spike vector x(t).
REQ-010 SHALL have ports: beta_shift  in  3  leak shift; beta*u = u - (u>>>beta_shift); 0 means no leak.
REQ-011 SHALL have ports: theta  in  WIDTH  signed firing threshold.
REQ-012 SHALL have ports: w_addr  out  clog2(N_NEURONS*N_INPUTS)  weight address = neuron*N_INPUTS + input.
REQ-013 SHALL have ports: w_data  in  WIDTH  signed weight, valid exactly 1 cycle after w_addr.
REQ-014 SHALL have ports: acc_beta_u, acc_sum_wx, acc_minus_teta  out  WIDTH each  accumulator operands.
REQ-015 SHALL have ports: acc_was_spike  out  1; acc_u_out  in  WIDTH  registered accumulator result (1-cycle latency).
REQ-016 SHALL have ports: spike_out  out  N_NEURONS  spike flags of the last completed timestep.

Function
REQ-017 SHALL hold per-neuron state internally: u[N_NEURONS] (WIDTH signed) and spk[N_NEURONS].
REQ-018 SHALL implement FSM IDLE -> LOAD -> ACC -> FIRE -> WB -> (LOAD for next neuron | DONE) -> IDLE.
REQ-019 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-020 SHALL latch spike_in, beta_shift, theta on the accepting start edge; mid-timestep changes have no effect.
REQ-021 LOAD (1 cycle): compute beta_u for the current neuron and register it; w_addr = first weight of the neuron.
REQ-022 ACC (N_INPUTS+1 cycles): issue w_addr for inputs 0..N_INPUTS-1 consecutively; add w_data into sum_wx when the latched spike bit is set; sum saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1] at every add.
REQ-023 FIRE (1 cycle): drive acc_beta_u, acc_sum_wx, acc_minus_teta = -theta (saturated), acc_was_spike = spk[n]; operands are stable only in FIRE and zero otherwise.
REQ-024 WB (1 cycle): u[n] <= acc_u_out; spk_next[n] <= (signed acc_u_out >= theta).
REQ-025 Neurons SHALL be processed in ascending index order 0..N_NEURONS-1; each takes exactly N_INPUTS+4 cycles.
REQ-026 DONE (1 cycle): done=1; spike_out and spk updated from spk_next atomically; return to IDLE.
REQ-027 busy SHALL be high in every state except IDLE: exactly N_NEURONS*(N_INPUTS+4)+1 cycles per timestep, with done on the last.
REQ-028 A start coincident with done SHALL be ignored; a start on the cycle after done SHALL be accepted.
REQ-029 spike_out SHALL not change except in DONE or on reset.

Reset
REQ-030 rst SHALL, on the next rising edge from any state, force IDLE, busy=0, done=0, spike_out=0, all u=0, all spk=0, sum_wx=0, acc_* outputs=0, w_addr=0.
REQ-031 rst SHALL take priority over start; a timestep interrupted by reset SHALL leave no partial spike_out update.

Structure
REQ-032 SHALL place the FSM state enum and the default parameter constants in a shared package (neuron_pkg).
REQ-033 SHALL use one sub-module, sat_add (signed WIDTH saturating adder), for the ACC accumulation and theta negation.
REQ-034 SHALL instantiate the accumulator externally; this block drives only its operand ports.

Verification
REQ-035 Reset during ACC of neuron 3 -> next cycle busy=0, spike_out=0; a subsequent start completes in 97 cycles (N=8, I=8).
REQ-036 Defaults, spike_in=0xFF, all w=+20, theta=100, beta_shift=0, model accumulator -> sum_wx saturates at 127; spike_out=0xFF at done.
REQ-037 spike_in=0x00, u=50 initially, beta_shift=1 -> acc_beta_u=25 and acc_sum_wx=0 for every neuron; spike_out=0x00.
REQ-038 start pulsed at cycles 5 and 40 after acceptance and on done cycle -> exactly one timestep runs; done high only at cycle 97.
REQ-039 w_data all -128, spike_in=0xFF -> sum_wx saturates at -128, no wrap; spk stays 0.
REQ-040 Random weights/spikes over 100 timesteps -> u and spike_out match a cycle-free reference model every done.
